// File: rtl/musicbox_pkg.sv
// Purpose : shared types for the music-box playlist path (FSM states, commands, repeat modes).
// Latency : n/a (types and a pure function only).
// Backpr. : n/a.
package musicbox_pkg;

   localparam int CLK_HZ = 50_000_000;

   localparam logic [1:0] RPT_OFF = 2'b00;
   localparam logic [1:0] RPT_ALL = 2'b01;
   localparam logic [1:0] RPT_ONE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_LOAD   = 3'd2,
      ST_PLAY   = 3'd3,
      ST_PAUSE  = 3'd4,
      ST_GAP    = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE = 3'd0,
      CMD_STOP = 3'd1,
      CMD_NEXT = 3'd2,
      CMD_PREV = 3'd3,
      CMD_PLAY = 3'd4,
      CMD_DONE = 3'd5
   } cmd_t;

   // One event per cycle; everything below the winner is dropped.
   function automatic cmd_t pick_cmd(input logic stop, input logic next, input logic prev,
                                     input logic play_pause, input logic done);
      cmd_t c;
      c = CMD_NONE;
      if (stop)            c = CMD_STOP;
      else if (next)       c = CMD_NEXT;
      else if (prev)       c = CMD_PREV;
      else if (play_pause) c = CMD_PLAY;
      else if (done)       c = CMD_DONE;
      return c;
   endfunction

endpackage

// File: rtl/playlist_ctrl_if.sv
// Purpose : player/track-table bundle between playlist_ctrl (master) and the note player + table (slave).
// Latency : wires only.
// Backpr. : none; pulses (start/abort/done) are single-cycle, hold is a level.
// Ports   : tbl_addr/tbl_data track-table lookup; ply_start/ply_addr/ply_hold/ply_abort commands; ply_done end-of-song.
interface playlist_ctrl_if #(
   parameter int TRK_W  = 3,
   parameter int ADDR_W = 16
);
   logic [TRK_W-1:0]  tbl_addr;
   logic [ADDR_W-1:0] tbl_data;
   logic              ply_start;
   logic [ADDR_W-1:0] ply_addr;
   logic              ply_hold;
   logic              ply_abort;
   logic              ply_done;

   modport master (
      output tbl_addr, ply_start, ply_addr, ply_hold, ply_abort,
      input  tbl_data, ply_done
   );

   modport slave (
      input  tbl_addr, ply_start, ply_addr, ply_hold, ply_abort,
      output tbl_data, ply_done
   );
endinterface

// File: rtl/playlist_ctrl_gap_timer.sv
// Purpose : loadable down-counter timing the silence between tracks; o_zero when expired.
// Latency : load takes effect next cycle; counts one per cycle, parks at zero.
// Backpr. : none.
// Ports   : i_clk, i_rst (sync, high), i_load/i_load_val load request, o_zero count==0.
module gap_timer #(
   parameter int GAP_W = 25
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [GAP_W-1:0] i_load_val,
   output logic             o_zero
);
   logic [GAP_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst)               r_cnt <= '0;
      else if (i_load)         r_cnt <= i_load_val;
      else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
   end

   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/playlist_ctrl.sv
// Purpose : playlist sequencer: owns the track number, turns buttons/done/repeat into player commands.
// Latency : play_pause at cycle n -> ply_start in n+3; ply_done -> next ply_start after the gap.
// Backpr. : none; button and done pulses are acted on in the cycle they arrive or dropped.
// Ports   : i_clk, i_rst (sync, high); i_play_pause/i_next/i_prev/i_stop pulses; i_repeat_mode;
//           io_ply player/table bundle (master); o_track display; o_playing activity flag.
module playlist_ctrl
   import musicbox_pkg::*;
#(
   parameter int N_TRACKS = 8,
   parameter int TRK_W    = 3,
   parameter int ADDR_W   = 16,
   parameter int GAP_CYC  = 25_000_000,
   parameter int GAP_W    = 25
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_play_pause,
   input  logic              i_next,
   input  logic              i_prev,
   input  logic              i_stop,
   input  logic [1:0]        i_repeat_mode,
   playlist_ctrl_if.master   io_ply,
   output logic [TRK_W-1:0]  o_track,
   output logic              o_playing
);
   // The ply_done cycle is already silent, so the gap counter starts one lower
   // than GAP_CYC-1 to keep done -> next ply_start at GAP_CYC+2 cycles.
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 2);
   localparam logic [TRK_W-1:0] TRK_LAST = TRK_W'(N_TRACKS - 1);

   state_t            r_state, w_state_nxt;
   logic [TRK_W-1:0]  r_track, w_track_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic              r_start, w_start_nxt;
   logic              r_hold, w_hold_nxt;
   logic              r_abort, w_abort_nxt;
   logic              r_playing;
   logic              w_gap_load, w_gap_zero;
   logic [TRK_W-1:0]  w_trk_inc, w_trk_dec;
   cmd_t              w_cmd;

   assign w_trk_inc = (r_track == TRK_LAST) ? '0 : r_track + 1'b1;
   assign w_trk_dec = (r_track == '0) ? TRK_LAST : r_track - 1'b1;
   assign w_cmd     = pick_cmd(i_stop, i_next, i_prev, i_play_pause, io_ply.ply_done);

   gap_timer #(.GAP_W(GAP_W)) u_gap (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_gap_load),
      .i_load_val (GAP_LOAD),
      .o_zero     (w_gap_zero)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_track   <= '0;
         r_addr    <= '0;
         r_start   <= 1'b0;
         r_hold    <= 1'b0;
         r_abort   <= 1'b0;
         r_playing <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_track   <= w_track_nxt;
         r_addr    <= w_addr_nxt;
         r_start   <= w_start_nxt;
         r_hold    <= w_hold_nxt;
         r_abort   <= w_abort_nxt;
         r_playing <= (w_state_nxt == ST_LOOKUP) || (w_state_nxt == ST_LOAD) ||
                      (w_state_nxt == ST_PLAY)   || (w_state_nxt == ST_GAP);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_track_nxt = r_track;
      w_addr_nxt  = r_addr;
      w_start_nxt = 1'b0;
      w_hold_nxt  = r_hold;
      w_abort_nxt = 1'b0;
      w_gap_load  = 1'b0;

      if (r_state == ST_IDLE) begin
         // Nothing to abort while idle; track may still be browsed.
         case (w_cmd)
            CMD_NEXT: w_track_nxt = w_trk_inc;
            CMD_PREV: w_track_nxt = w_trk_dec;
            CMD_PLAY: w_state_nxt = ST_LOOKUP;
            default:  ;
         endcase
      end else if (w_cmd == CMD_STOP) begin
         w_abort_nxt = 1'b1;
         w_hold_nxt  = 1'b0;
         w_state_nxt = ST_IDLE;
      end else if (w_cmd == CMD_NEXT || w_cmd == CMD_PREV) begin
         // Restart via a fresh lookup; the new ply_start re-arms the player.
         w_track_nxt = (w_cmd == CMD_NEXT) ? w_trk_inc : w_trk_dec;
         w_hold_nxt  = 1'b0;
         w_state_nxt = ST_LOOKUP;
      end else begin
         case (r_state)
            ST_LOOKUP: w_state_nxt = ST_LOAD;
            ST_LOAD: begin
               w_addr_nxt  = io_ply.tbl_data;
               w_start_nxt = 1'b1;
               w_hold_nxt  = 1'b0;
               w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
               if (w_cmd == CMD_PLAY) begin
                  w_hold_nxt  = 1'b1;
                  w_state_nxt = ST_PAUSE;
               end else if (w_cmd == CMD_DONE) begin
                  w_gap_load  = 1'b1;
                  w_state_nxt = ST_GAP;
                  case (i_repeat_mode)
                     RPT_ONE: ;
                     RPT_ALL: w_track_nxt = w_trk_inc;
                     default: begin
                        if (r_track != TRK_LAST) begin
                           w_track_nxt = w_trk_inc;
                        end else begin
                           // End of playlist without repeat.
                           w_track_nxt = '0;
                           w_gap_load  = 1'b0;
                           w_state_nxt = ST_IDLE;
                        end
                     end
                  endcase
               end
            end
            ST_PAUSE: begin
               if (w_cmd == CMD_PLAY) begin
                  w_hold_nxt  = 1'b0;
                  w_state_nxt = ST_PLAY;
               end
            end
            ST_GAP: begin
               if (w_gap_zero) w_state_nxt = ST_LOOKUP;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign io_ply.tbl_addr  = r_track;
   assign io_ply.ply_start = r_start;
   assign io_ply.ply_addr  = r_addr;
   assign io_ply.ply_hold  = r_hold;
   assign io_ply.ply_abort = r_abort;
   assign o_track          = r_track;
   assign o_playing        = r_playing;
endmodule
